spi_target_shifter: RTL

SPI target (slave) end of the SD-card SPI link. It receives SCLK/MOSI/CS_n from an SPI initiator and returns MISO, with the same framing as our initiator shifter: mode 0, MSB first, byte units, CRC16-CCITT. It is used as the card-side model in system benches, and as a debug target port on the controller. It runs on the system clock and oversamples SCLK.

---
 rtl/spi_target_shifter_pkg.sv | 30 +++
 rtl/spi_in_sync.sv | 69 ++++++
 rtl/spi_target_shifter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/spi_target_shifter_pkg.sv
// -----------------------------------------------------------------------------
// spi_target_shifter_pkg
// Constants shared by the SPI initiator and target shifters of the SD-card
// link: CRC16-CCITT polynomial, idle fill byte, SPI mode (mode 0) and the CRC
// source selector encoding. Also provides a single-bit CRC16 update helper.
// -----------------------------------------------------------------------------
package spi_target_shifter_pkg;

    // x^16 + x^12 + x^5 + 1, MSB-first, init 0, no final xor
    localparam logic [15:0] CRC16_POLY        = 16'h1021;
    localparam logic [7:0]  IDLE_FILL_DEFAULT = 8'hFF;

    // SPI mode 0: SCLK idles low, data sampled on the leading (rising) edge
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    typedef enum logic {
        CRC_SRC_MOSI = 1'b0,
        CRC_SRC_MISO = 1'b1
    } crc_src_e;

    // One serial CRC16 step: feedback is the incoming bit xor the CRC MSB.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic        din);
        logic fb;
        fb = din ^ crc[15];
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// -----------------------------------------------------------------------------
// spi_in_sync
// Brings the asynchronous SPI pins into the clk domain and derives edge pulses.
//   clk, rst          system clock, async active-high reset
//   cs_n, sclk, mosi  raw SPI pins
//   mosi_s            synchronized MOSI
//   sclk_rise/fall    one-cycle pulses on synchronized SCLK edges
//   cs_fall/rise      one-cycle pulses on synchronized CS_n edges (select/deselect)
// SYNC_STAGES must be at least 2.
// -----------------------------------------------------------------------------
module spi_in_sync
    import spi_target_shifter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cs_n,
    input  logic sclk,
    input  logic mosi,
    output logic mosi_s,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise
);

    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q,   cs_prev_d;
    logic                   cs_n_s, sclk_s;

    always_comb begin
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   cs_n};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
        cs_prev_d   = cs_sync_q[SYNC_STAGES-1];
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= {SYNC_STAGES{SPI_CPOL}};
            mosi_sync_q <= '0;
            sclk_prev_q <= SPI_CPOL;
            cs_prev_q   <= 1'b1;
        end else begin
            cs_sync_q   <= cs_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
        end
    end

    assign cs_n_s    = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise =  sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s &  sclk_prev_q;
    assign cs_fall   = ~cs_n_s &  cs_prev_q;
    assign cs_rise   =  cs_n_s & ~cs_prev_q;

endmodule

// File: rtl/spi_target_shifter.sv
// -----------------------------------------------------------------------------
// spi_target_shifter
// SPI target (mode 0, MSB first, byte framing) running on the system clock and
// oversampling SCLK. Keeps a one-byte tx holding buffer and a running CRC16.
//   clk, rst              system clock, async active-high reset
//   cs_n, sclk, mosi      SPI pins from the initiator (async to clk)
//   miso, miso_oe         SPI data to initiator and its output enable
//   tx_data, tx_load      write into the holding buffer (only when tx_ready)
//   tx_ready              holding buffer empty
//   rx_data, rx_valid     last received byte, one-cycle update pulse
//   tx_underrun           one-cycle pulse: IDLE_FILL sent instead of a tx byte
//   crc_reset, crc_source CRC clear (idle cycles only), input select MOSI/MISO
//   crc_out               running CRC16
//   busy                  selected and mid-byte
// -----------------------------------------------------------------------------
module spi_target_shifter
    import spi_target_shifter_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_FILL   = IDLE_FILL_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_n,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [7:0]  tx_data,
    input  logic        tx_load,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        tx_underrun,
    input  logic        crc_reset,
    input  logic        crc_source,
    output logic [15:0] crc_out,
    output logic        busy
);

    // Mode 0 samples on the leading edge (rise) and shifts on the trailing one.
    localparam logic SAMPLE_ON_RISE = (SPI_CPOL == SPI_CPHA);

    logic mosi_s, sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic sample_edge, shift_edge;

    spi_in_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_in_sync (
        .clk       (clk),
        .rst       (rst),
        .cs_n      (cs_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .mosi_s    (mosi_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise)
    );

    assign sample_edge = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;
    assign shift_edge  = SAMPLE_ON_RISE ? sclk_fall : sclk_rise;

    logic        sel_q,         sel_d;
    logic [2:0]  bit_cnt_q,     bit_cnt_d;
    logic [7:0]  tx_shift_q,    tx_shift_d;
    logic [7:0]  rx_shift_q,    rx_shift_d;
    logic [7:0]  rx_data_q,     rx_data_d;
    logic        rx_valid_q,    rx_valid_d;
    logic        tx_underrun_q, tx_underrun_d;
    logic [7:0]  tx_buf_q,      tx_buf_d;
    logic        tx_ready_q,    tx_ready_d;
    logic [15:0] crc_q,         crc_d;

    logic        reload;
    logic        crc_shift;
    logic        crc_in;

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        sel_d         = sel_q;
        bit_cnt_d     = bit_cnt_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        tx_buf_d      = tx_buf_q;
        tx_ready_d    = tx_ready_q;
        crc_d         = crc_q;
        reload        = 1'b0;
        crc_shift     = 1'b0;
        crc_in        = 1'b0;

        // Loads only land in an empty buffer, so they never collide with the
        // consume below (which only happens when the buffer is full).
        if (tx_load && tx_ready_q) begin
            tx_buf_d   = tx_data;
            tx_ready_d = 1'b0;
        end

        if (cs_rise) begin
            // Partial rx/tx bytes are dropped; buffer and CRC are kept.
            sel_d     = 1'b0;
            bit_cnt_d = 3'd0;
        end else if (cs_fall) begin
            sel_d     = 1'b1;
            bit_cnt_d = 3'd0;
            reload    = 1'b1;
        end else if (sel_q) begin
            if (sample_edge) begin
                rx_shift_d = {rx_shift_q[6:0], mosi_s};
                bit_cnt_d  = bit_cnt_q + 3'd1;
                crc_shift  = 1'b1;
                crc_in     = (crc_source == CRC_SRC_MISO) ? tx_shift_q[7] : mosi_s;
                if (bit_cnt_q == 3'd7) begin
                    rx_data_d  = {rx_shift_q[6:0], mosi_s};
                    rx_valid_d = 1'b1;
                end
            end else if (shift_edge) begin
                if (bit_cnt_q != 3'd0) begin
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                end else begin
                    reload = 1'b1;
                end
            end
        end

        // Byte boundary: take the buffered byte, or fill and flag underrun.
        if (reload) begin
            if (!tx_ready_q) begin
                tx_shift_d = tx_buf_q;
                tx_ready_d = 1'b1;
            end else begin
                tx_shift_d    = IDLE_FILL;
                tx_underrun_d = 1'b1;
            end
        end

        // A shift beats crc_reset; a held reset then lands on the next idle cycle.
        if (crc_shift) begin
            crc_d = crc16_step(crc_q, crc_in);
        end else if (crc_reset) begin
            crc_d = 16'h0000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q         <= 1'b0;
            bit_cnt_q     <= 3'd0;
            tx_shift_q    <= 8'h00;
            rx_shift_q    <= 8'h00;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            tx_buf_q      <= 8'h00;
            tx_ready_q    <= 1'b1;
            crc_q         <= 16'h0000;
        end else begin
            sel_q         <= sel_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_underrun_q <= tx_underrun_d;
            tx_buf_q      <= tx_buf_d;
            tx_ready_q    <= tx_ready_d;
            crc_q         <= crc_d;
        end
    end

    // MISO follows tx_shift[7] directly so bit 7 is on the wire before the
    // first rising SCLK; it idles high when deselected.
    assign miso        = sel_q ? tx_shift_q[7] : 1'b1;
    assign miso_oe     = sel_q;
    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = tx_underrun_q;
    assign crc_out     = crc_q;
    assign busy        = (bit_cnt_q != 3'd0);

endmodule
